// File: rtl/fetch_pc_unit_pkg.sv
// Shared pipeline constants, the IF/ID entry layout and the mispredict rule
// used by the fetch PC generator.
package fetch_pc_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSN_BYTES = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
    } ifid_t;

    // A taken branch whose target differs from the carried prediction is a
    // mispredict even if the direction was guessed correctly.
    function automatic logic is_mispredict(
        input logic            valid,
        input logic            taken,
        input logic [XLEN-1:0] target,
        input logic            pred_taken,
        input logic [XLEN-1:0] pred_target
    );
        return valid && ((taken != pred_taken) || (taken && (target != pred_target)));
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bus: EX branch resolution in, predictor lookup/update and
// IF/ID contents out.
interface fetch_pc_unit_if;
    import fetch_pc_unit_pkg::*;

    logic            stall;
    logic            ex_br_valid;
    logic [XLEN-1:0] ex_br_pc;
    logic            ex_br_taken;
    logic [XLEN-1:0] ex_br_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic [XLEN-1:0] bp_lookup_pc;
    logic            bp_predict_taken;
    logic            bp_update_valid;
    logic [XLEN-1:0] bp_update_pc;
    logic            bp_update_taken;
    logic [XLEN-1:0] imem_addr;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic            if_pred_taken;
    logic [XLEN-1:0] if_pred_target;
    logic            flush;
    logic [XLEN-1:0] mispredict_count;
    logic [XLEN-1:0] branch_count;

    modport master (
        output stall, ex_br_valid, ex_br_pc, ex_br_taken, ex_br_target,
               ex_pred_taken, ex_pred_target, bp_predict_taken,
        input  bp_lookup_pc, bp_update_valid, bp_update_pc, bp_update_taken,
               imem_addr, if_valid, if_pc, if_pred_taken, if_pred_target,
               flush, mispredict_count, branch_count
    );

    modport slave (
        input  stall, ex_br_valid, ex_br_pc, ex_br_taken, ex_br_target,
               ex_pred_taken, ex_pred_target, bp_predict_taken,
        output bp_lookup_pc, bp_update_valid, bp_update_pc, bp_update_taken,
               imem_addr, if_valid, if_pc, if_pred_taken, if_pred_target,
               flush, mispredict_count, branch_count
    );

endinterface

// File: rtl/fetch_pc_unit_btb.sv
// Direct-mapped branch target buffer: combinational lookup, clocked write,
// valid bits cleared asynchronously by reset.
module fetch_btb
    import fetch_pc_unit_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IW      = $clog2(ENTRIES),
    parameter int TW      = XLEN - 2 - IW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IW-1:0]   rd_idx,
    input  logic [TW-1:0]   rd_tag,
    output logic            rd_hit,
    output logic [XLEN-1:0] rd_target,
    input  logic            wr_en,
    input  logic [IW-1:0]   wr_idx,
    input  logic [TW-1:0]   wr_tag,
    input  logic [XLEN-1:0] wr_target
);

    logic [ENTRIES-1:0] valid_q;
    logic [TW-1:0]      tag_mem    [ENTRIES];
    logic [XLEN-1:0]    target_mem [ENTRIES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Payload needs no reset; a cleared valid bit masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]    <= wr_tag;
            target_mem[wr_idx] <= wr_target;
        end
    end

    assign rd_hit    = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_target = target_mem[rd_idx];

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: BTB + direction-predictor next-PC selection, EX-stage
// redirect, IF/ID register, predictor-update strobe and branch statistics.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int              BTB_ENTRIES = 16
) (
    input  logic          clk,
    input  logic          reset,
    fetch_pc_unit_if.slave bus
);

    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int TW = XLEN - 2 - IW;

    logic [XLEN-1:0] pc_q;
    ifid_t           ifid_q;
    logic            flush_q;
    logic            upd_valid_q;
    logic [XLEN-1:0] upd_pc_q;
    logic            upd_taken_q;
    logic [XLEN-1:0] mispredict_count_q;
    logic [XLEN-1:0] branch_count_q;

    logic            btb_hit;
    logic [XLEN-1:0] btb_target;
    logic [XLEN-1:0] pc_plus4;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] redirect_pc;
    logic            mispredict;

    fetch_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (pc_q[2+IW-1:2]),
        .rd_tag    (pc_q[XLEN-1:2+IW]),
        .rd_hit    (btb_hit),
        .rd_target (btb_target),
        .wr_en     (bus.ex_br_valid && bus.ex_br_taken),
        .wr_idx    (bus.ex_br_pc[2+IW-1:2]),
        .wr_tag    (bus.ex_br_pc[XLEN-1:2+IW]),
        .wr_target (bus.ex_br_target)
    );

    assign pc_plus4    = pc_q + INSN_BYTES;
    assign pred_taken  = btb_hit && bus.bp_predict_taken;
    assign pred_target = btb_hit ? btb_target : pc_plus4;
    assign next_pc     = pred_taken ? pred_target : pc_plus4;
    assign redirect_pc = bus.ex_br_taken ? bus.ex_br_target : (bus.ex_br_pc + INSN_BYTES);
    assign mispredict  = is_mispredict(bus.ex_br_valid, bus.ex_br_taken, bus.ex_br_target,
                                       bus.ex_pred_taken, bus.ex_pred_target);

    // A mispredict redirects even under stall; the wrong-path IF/ID slot becomes a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            ifid_q  <= '{valid: 1'b0, pc: RESET_PC, pred_taken: 1'b0, pred_target: '0};
            flush_q <= 1'b0;
        end else if (mispredict) begin
            pc_q         <= redirect_pc;
            ifid_q.valid <= 1'b0;
            flush_q      <= 1'b1;
        end else if (bus.stall) begin
            flush_q <= 1'b0;
        end else begin
            pc_q    <= next_pc;
            ifid_q  <= '{valid: 1'b1, pc: pc_q, pred_taken: pred_taken, pred_target: pred_target};
            flush_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_valid_q <= 1'b0;
            upd_pc_q    <= '0;
            upd_taken_q <= 1'b0;
        end else begin
            upd_valid_q <= bus.ex_br_valid;
            if (bus.ex_br_valid) begin
                upd_pc_q    <= bus.ex_br_pc;
                upd_taken_q <= bus.ex_br_taken;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (bus.ex_br_valid) begin
                branch_count_q <= branch_count_q + 1'b1;
            end
            if (mispredict) begin
                mispredict_count_q <= mispredict_count_q + 1'b1;
            end
        end
    end

    assign bus.bp_lookup_pc     = pc_q;
    assign bus.imem_addr        = pc_q;
    assign bus.if_valid         = ifid_q.valid;
    assign bus.if_pc            = ifid_q.pc;
    assign bus.if_pred_taken    = ifid_q.pred_taken;
    assign bus.if_pred_target   = ifid_q.pred_target;
    assign bus.flush            = flush_q;
    assign bus.bp_update_valid  = upd_valid_q;
    assign bus.bp_update_pc     = upd_pc_q;
    assign bus.bp_update_taken  = upd_taken_q;
    assign bus.mispredict_count = mispredict_count_q;
    assign bus.branch_count     = branch_count_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, redirects, BTB hits,
// stall, aliasing, address wrap and asynchronous reset.
module tb_fetch_pc_unit;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(
        .RESET_PC    (32'h0000_0000),
        .BTB_ENTRIES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [31:0] br_pc, input logic taken,
                                  input logic [31:0] target, input logic p_taken, input logic [31:0] p_target);
        bus.ex_br_valid    = valid;
        bus.ex_br_pc       = br_pc;
        bus.ex_br_taken    = taken;
        bus.ex_br_target   = target;
        bus.ex_pred_taken  = p_taken;
        bus.ex_pred_target = p_target;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        bus.stall    = 1'b0;
        bus.bp_predict_taken = 1'b0;
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        #12;
        check_output("rst_pc", bus.bp_lookup_pc, 32'h0);
        check_output("rst_if_valid", bus.if_valid, 32'h0);
        check_output("rst_if_pc", bus.if_pc, 32'h0);
        check_output("rst_flush", bus.flush, 32'h0);
        check_output("rst_upd_valid", bus.bp_update_valid, 32'h0);
        check_output("rst_br_count", bus.branch_count, 32'h0);
        reset = 1'b0;

        // Four sequential fetches with an empty BTB.
        tick();
        check_output("seq0_if_valid", bus.if_valid, 32'h1);
        check_output("seq0_if_pc", bus.if_pc, 32'h0);
        tick();
        check_output("seq1_if_pc", bus.if_pc, 32'h4);
        tick();
        check_output("seq2_if_pc", bus.if_pc, 32'h8);
        tick();
        check_output("seq3_if_pc", bus.if_pc, 32'hC);
        check_output("seq3_imem", bus.imem_addr, 32'h10);
        check_output("seq3_upd_valid", bus.bp_update_valid, 32'h0);

        // Taken branch at 0x10 to 0x40, predicted not-taken.
        apply_stimulus(1'b1, 32'h10, 1'b1, 32'h40, 1'b0, 32'h0);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_output("mp1_flush", bus.flush, 32'h1);
        check_output("mp1_if_valid", bus.if_valid, 32'h0);
        check_output("mp1_pc", bus.imem_addr, 32'h40);
        check_output("mp1_upd_valid", bus.bp_update_valid, 32'h1);
        check_output("mp1_upd_pc", bus.bp_update_pc, 32'h10);
        check_output("mp1_upd_taken", bus.bp_update_taken, 32'h1);
        check_output("mp1_br_count", bus.branch_count, 32'h1);
        check_output("mp1_mp_count", bus.mispredict_count, 32'h1);
        tick();
        check_output("mp1b_flush", bus.flush, 32'h0);
        check_output("mp1b_upd_valid", bus.bp_update_valid, 32'h0);
        check_output("mp1b_if_valid", bus.if_valid, 32'h1);
        check_output("mp1b_if_pc", bus.if_pc, 32'h40);
        check_output("mp1b_pc", bus.bp_lookup_pc, 32'h44);

        // Not-taken mispredict from 0x0C steers fetch back to 0x10; BTB hit, predictor taken.
        apply_stimulus(1'b1, 32'hC, 1'b0, 32'h0, 1'b1, 32'h80);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_output("rd1_pc", bus.bp_lookup_pc, 32'h10);
        check_output("rd1_upd_taken", bus.bp_update_taken, 32'h0);
        bus.bp_predict_taken = 1'b1;
        tick();
        check_output("hit_t_if_pc", bus.if_pc, 32'h10);
        check_output("hit_t_pred", bus.if_pred_taken, 32'h1);
        check_output("hit_t_target", bus.if_pred_target, 32'h40);
        check_output("hit_t_next_pc", bus.bp_lookup_pc, 32'h40);

        // Same fetch with predictor saying not-taken: fall through, target still reported.
        apply_stimulus(1'b1, 32'hC, 1'b0, 32'h0, 1'b1, 32'h80);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        bus.bp_predict_taken = 1'b0;
        tick();
        check_output("hit_nt_pred", bus.if_pred_taken, 32'h0);
        check_output("hit_nt_target", bus.if_pred_target, 32'h40);
        check_output("hit_nt_next_pc", bus.bp_lookup_pc, 32'h14);
        check_output("hit_nt_mp_count", bus.mispredict_count, 32'h3);

        // Three stalled cycles hold everything.
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("stall_pc", bus.bp_lookup_pc, 32'h14);
            check_output("stall_if_pc", bus.if_pc, 32'h10);
            check_output("stall_if_valid", bus.if_valid, 32'h1);
        end

        // Target mismatch mispredict while stalled still redirects.
        apply_stimulus(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h204);
        tick();
        check_output("stall_mp_pc", bus.bp_lookup_pc, 32'h200);
        check_output("stall_mp_flush", bus.flush, 32'h1);
        check_output("stall_mp_if_valid", bus.if_valid, 32'h0);
        check_output("stall_mp_count", bus.mispredict_count, 32'h4);
        bus.stall = 1'b0;

        // Correct prediction, then a back-to-back not-taken resolution.
        apply_stimulus(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        tick();
        check_output("ok_br_count", bus.branch_count, 32'h5);
        check_output("ok_mp_count", bus.mispredict_count, 32'h4);
        check_output("ok_flush", bus.flush, 32'h0);
        check_output("ok_if_pc", bus.if_pc, 32'h200);
        check_output("ok_pc", bus.bp_lookup_pc, 32'h204);
        apply_stimulus(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_output("b2b_upd_valid", bus.bp_update_valid, 32'h1);
        check_output("b2b_upd_pc", bus.bp_update_pc, 32'h104);
        check_output("b2b_upd_taken", bus.bp_update_taken, 32'h0);
        check_output("b2b_br_count", bus.branch_count, 32'h6);
        tick();
        check_output("b2b_end_upd_valid", bus.bp_update_valid, 32'h0);

        // 0x50 shares an index with 0x10 but not its tag.
        apply_stimulus(1'b1, 32'h4C, 1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        bus.bp_predict_taken = 1'b1;
        tick();
        check_output("alias_if_pc", bus.if_pc, 32'h50);
        check_output("alias_pred", bus.if_pred_taken, 32'h0);
        check_output("alias_target", bus.if_pred_target, 32'h54);
        check_output("alias_next_pc", bus.bp_lookup_pc, 32'h54);
        bus.bp_predict_taken = 1'b0;

        // Address wrap at the top of the space.
        apply_stimulus(1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_output("wrap_pc", bus.bp_lookup_pc, 32'hFFFF_FFFC);
        tick();
        check_output("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFC);
        check_output("wrap_next_pc", bus.bp_lookup_pc, 32'h0);

        // Reset asserted between edges right after a redirect.
        apply_stimulus(1'b1, 32'h10, 1'b1, 32'h80, 1'b0, 32'h0);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_output("pre_rst_flush", bus.flush, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_output("async_rst_pc", bus.bp_lookup_pc, 32'h0);
        check_output("async_rst_flush", bus.flush, 32'h0);
        check_output("async_rst_if_valid", bus.if_valid, 32'h0);
        check_output("async_rst_upd_valid", bus.bp_update_valid, 32'h0);
        check_output("async_rst_br_count", bus.branch_count, 32'h0);
        check_output("async_rst_mp_count", bus.mispredict_count, 32'h0);
        #1;
        reset = 1'b0;

        // BTB must be empty again: 0x10 misses even with predictor taken.
        apply_stimulus(1'b1, 32'hC, 1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        bus.bp_predict_taken = 1'b1;
        tick();
        check_output("post_rst_if_pc", bus.if_pc, 32'h10);
        check_output("post_rst_pred", bus.if_pred_taken, 32'h0);
        check_output("post_rst_next_pc", bus.bp_lookup_pc, 32'h14);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
